// File: rtl/cvp_vmem_seq.sv
// Vector load/store sequencer: moves VLen elements between memory (base + i*stride)
// and one vector register, with a MemRdy wait-state handshake on every access.
module cvp_vmem_seq #(
    parameter int unsigned DW    = 16,
    parameter int unsigned AW    = 16,
    parameter int unsigned ELEMS = 16
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Start,
    input  logic                       Op,
    input  logic [AW-1:0]              Base,
    input  logic [AW-1:0]              Stride,
    input  logic [$clog2(ELEMS):0]     VLen,
    output logic [AW-1:0]              Addr,
    output logic                       RD,
    output logic                       WR,
    output logic [DW-1:0]              DataOut,
    input  logic [DW-1:0]              DataIn,
    input  logic                       MemRdy,
    output logic [$clog2(ELEMS)-1:0]   VIdx,
    output logic                       VWE,
    output logic [DW-1:0]              VWrData,
    input  logic [DW-1:0]              VRdData,
    output logic                       Busy,
    output logic                       Done,
    output logic                       Wrap
);

    localparam int unsigned IW = $clog2(ELEMS);
    localparam logic [IW:0] ELEMS_L = (IW+1)'(ELEMS);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LD_REQ   = 3'd1,
        LD_WB    = 3'd2,
        ST_FETCH = 3'd3,
        ST_REQ   = 3'd4,
        FIN      = 3'd5
    } state_t;

    state_t          state, stateNext;
    logic [IW-1:0]   idx, idxNext;
    logic [IW:0]     vlenQ, vlenNext;
    logic [AW-1:0]   strideQ, strideNext;
    logic [AW-1:0]   elemAddr, elemAddrNext;
    logic [AW-1:0]   addrNext;
    logic            rdNext, wrNext, vweNext, busyNext, doneNext, wrapNext;
    logic [DW-1:0]   dataOutNext, vwrDataNext;
    logic [IW-1:0]   vidxNext;

    logic [IW:0]     vlenClamp;
    logic [AW:0]     addrSum;
    logic            isLast;

    // Carry out of the address adder flags a wrap past 2^AW
    assign vlenClamp = (VLen > ELEMS_L) ? ELEMS_L : VLen;
    assign addrSum   = {1'b0, elemAddr} + {1'b0, strideQ};
    assign isLast    = ({1'b0, idx} == (vlenQ - (IW+1)'(1)));

    // State and registered outputs
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            idx      <= '0;
            vlenQ    <= '0;
            strideQ  <= '0;
            elemAddr <= '0;
            Addr     <= '0;
            RD       <= 1'b0;
            WR       <= 1'b0;
            DataOut  <= '0;
            VIdx     <= '0;
            VWE      <= 1'b0;
            VWrData  <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Wrap     <= 1'b0;
        end else begin
            state    <= stateNext;
            idx      <= idxNext;
            vlenQ    <= vlenNext;
            strideQ  <= strideNext;
            elemAddr <= elemAddrNext;
            Addr     <= addrNext;
            RD       <= rdNext;
            WR       <= wrNext;
            DataOut  <= dataOutNext;
            VIdx     <= vidxNext;
            VWE      <= vweNext;
            VWrData  <= vwrDataNext;
            Busy     <= busyNext;
            Done     <= doneNext;
            Wrap     <= wrapNext;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        stateNext    = state;
        idxNext      = idx;
        vlenNext     = vlenQ;
        strideNext   = strideQ;
        elemAddrNext = elemAddr;
        addrNext     = Addr;
        rdNext       = RD;
        wrNext       = WR;
        dataOutNext  = DataOut;
        vidxNext     = VIdx;
        vweNext      = 1'b0;
        vwrDataNext  = VWrData;
        busyNext     = Busy;
        doneNext     = 1'b0;
        wrapNext     = Wrap;

        case (state)
            IDLE: begin
                if (Start) begin
                    vlenNext     = vlenClamp;
                    strideNext   = Stride;
                    elemAddrNext = Base;
                    idxNext      = '0;
                    wrapNext     = 1'b0;
                    busyNext     = 1'b1;
                    if (vlenClamp == '0) begin
                        stateNext = FIN;
                    end else if (!Op) begin
                        addrNext  = Base;
                        rdNext    = 1'b1;
                        stateNext = LD_REQ;
                    end else begin
                        vidxNext  = '0;
                        stateNext = ST_FETCH;
                    end
                end
            end
            LD_REQ: begin
                if (MemRdy) begin
                    vwrDataNext = DataIn;
                    vidxNext    = idx;
                    vweNext     = 1'b1;
                    rdNext      = 1'b0;
                    stateNext   = LD_WB;
                end
            end
            LD_WB: begin
                if (isLast) begin
                    stateNext = FIN;
                end else begin
                    idxNext      = idx + IW'(1);
                    elemAddrNext = addrSum[AW-1:0];
                    addrNext     = addrSum[AW-1:0];
                    wrapNext     = Wrap | addrSum[AW];
                    rdNext       = 1'b1;
                    stateNext    = LD_REQ;
                end
            end
            ST_FETCH: begin
                // VRdData reflects VIdx presented during this cycle
                dataOutNext = VRdData;
                addrNext    = elemAddr;
                wrNext      = 1'b1;
                stateNext   = ST_REQ;
            end
            ST_REQ: begin
                if (MemRdy) begin
                    wrNext = 1'b0;
                    if (isLast) begin
                        stateNext = FIN;
                    end else begin
                        idxNext      = idx + IW'(1);
                        vidxNext     = idx + IW'(1);
                        elemAddrNext = addrSum[AW-1:0];
                        wrapNext     = Wrap | addrSum[AW];
                        stateNext    = ST_FETCH;
                    end
                end
            end
            FIN: begin
                doneNext  = 1'b1;
                busyNext  = 1'b0;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cvp_vmem_seq.sv
// Randomized bench for cvp_vmem_seq: wait-state memory responder, event monitor and
// a per-transaction reference computed from base/stride/length arithmetic.
module tb_cvp_vmem_seq;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 16;
    localparam int unsigned ELEMS = 16;
    localparam int unsigned IW    = 4;

    logic              Clk;
    logic              Reset;
    logic              Start;
    logic              Op;
    logic [AW-1:0]     Base;
    logic [AW-1:0]     Stride;
    logic [IW:0]       VLen;
    logic [AW-1:0]     Addr;
    logic              RD;
    logic              WR;
    logic [DW-1:0]     DataOut;
    logic [DW-1:0]     DataIn;
    logic              MemRdy;
    logic [IW-1:0]     VIdx;
    logic              VWE;
    logic [DW-1:0]     VWrData;
    logic [DW-1:0]     VRdData;
    logic              Busy;
    logic              Done;
    logic              Wrap;

    cvp_vmem_seq #(.DW(DW), .AW(AW), .ELEMS(ELEMS)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .Base(Base), .Stride(Stride),
        .VLen(VLen), .Addr(Addr), .RD(RD), .WR(WR), .DataOut(DataOut), .DataIn(DataIn),
        .MemRdy(MemRdy), .VIdx(VIdx), .VWE(VWE), .VWrData(VWrData), .VRdData(VRdData),
        .Busy(Busy), .Done(Done), .Wrap(Wrap)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [DW-1:0] mem  [0:(1<<AW)-1];
    logic [DW-1:0] vreg [0:ELEMS-1];

    assign DataIn  = mem[Addr];
    assign VRdData = vreg[VIdx];

    int unsigned waitCnt = 0;
    int unsigned waitCur = 0;
    int unsigned waitMin = 0;
    int unsigned waitMax = 0;

    assign MemRdy = (RD || WR) && (waitCnt >= waitCur);

    // Memory wait-state generator; a fresh wait count is drawn whenever the bus is idle
    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            waitCnt <= 0;
        end else if (RD || WR) begin
            if (MemRdy) waitCnt <= 0;
            else        waitCnt <= waitCnt + 1;
        end else begin
            waitCnt <= 0;
            waitCur <= $urandom_range(waitMax, waitMin);
        end
    end

    logic [31:0] rdQ[$], wrAddrQ[$], wrDataQ[$], vwIdxQ[$], vwDataQ[$];
    int unsigned doneCnt  = 0;
    int unsigned protoErr = 0;
    int unsigned holdErr  = 0;
    logic          holdPend = 1'b0;
    logic [AW-1:0] holdAddr = '0;
    logic [DW-1:0] holdData = '0;
    logic          holdRd   = 1'b0;
    logic          holdWr   = 1'b0;

    // Bus monitor: records completed accesses and vreg writes, checks request hold
    always @(negedge Clk) begin
        if (RD && MemRdy) rdQ.push_back(32'(Addr));
        if (WR && MemRdy) begin
            wrAddrQ.push_back(32'(Addr));
            wrDataQ.push_back(32'(DataOut));
        end
        if (VWE) begin
            vwIdxQ.push_back(32'(VIdx));
            vwDataQ.push_back(32'(VWrData));
        end
        if (Done) doneCnt <= doneCnt + 1;
        if ((RD && WR) || (VWE && WR)) protoErr <= protoErr + 1;
        if (holdPend && Reset &&
            (Addr != holdAddr || RD != holdRd || WR != holdWr || (WR && DataOut != holdData)))
            holdErr <= holdErr + 1;
        holdPend <= Reset && (RD || WR) && !MemRdy;
        holdAddr <= Addr;
        holdData <= DataOut;
        holdRd   <= RD;
        holdWr   <= WR;
    end

    int nCmp = 0;
    int nBad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCmp++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clearQueues();
        rdQ.delete();
        wrAddrQ.delete();
        wrDataQ.delete();
        vwIdxQ.delete();
        vwDataQ.delete();
    endtask

    // One transaction against the reference: expected addresses, data, wrap and timing
    task automatic runTxn(input logic op, input logic [AW-1:0] base, input logic [AW-1:0] stride,
                          input logic [IW:0] vlen, input int unsigned wmin, input int unsigned wmax,
                          input bit extra, input string name);
        int n;
        int k;
        int m;
        bit timedOut;
        bit wrapExp;
        int unsigned d0;
        logic [AW-1:0] addrs[$];
        n = (int'(vlen) > int'(ELEMS)) ? int'(ELEMS) : int'(vlen);
        for (int i = 0; i < n; i++)
            addrs.push_back(AW'((longint'(base) + longint'(i) * longint'(stride)) % 65536));
        wrapExp = (n > 0) && ((longint'(base) + longint'(n - 1) * longint'(stride)) >= 65536);
        if (!op) begin
            for (int i = 0; i < n; i++) mem[addrs[i]] = DW'($urandom);
        end else begin
            for (int e = 0; e < int'(ELEMS); e++) vreg[e] = DW'($urandom);
        end
        waitMin = wmin;
        waitMax = wmax;
        @(negedge Clk);
        clearQueues();
        d0 = doneCnt;
        Start = 1'b1; Op = op; Base = base; Stride = stride; VLen = vlen;
        k = 0;
        timedOut = 1'b0;
        while (1) begin
            @(negedge Clk);
            k++;
            Start = 1'b0;
            if (extra && k == 3) begin
                Start = 1'b1; Op = ~op; Base = AW'($urandom); Stride = AW'($urandom);
                VLen = (IW+1)'(ELEMS);
            end
            if (k == 1) check({name, ".busy"}, 32'(Busy), 32'd1);
            if (Done) break;
            if (k > 4000) begin
                check({name, ".done_timeout"}, 32'd0, 32'd1);
                timedOut = 1'b1;
                break;
            end
        end
        Start = 1'b0;
        if (wmax == 0 && !timedOut) check({name, ".latency"}, 32'(k), 32'(2 * n + 2));
        check({name, ".busy_at_done"}, 32'(Busy), 32'd0);
        check({name, ".wrap"}, 32'(Wrap), 32'(wrapExp));
        repeat (3) @(negedge Clk);
        check({name, ".done_count"}, doneCnt - d0, 32'd1);
        if (!op) begin
            check({name, ".rd_count"}, 32'(rdQ.size()), 32'(n));
            check({name, ".vwe_count"}, 32'(vwIdxQ.size()), 32'(n));
            check({name, ".wr_count"}, 32'(wrAddrQ.size()), 32'd0);
            m = (rdQ.size() < n) ? rdQ.size() : n;
            for (int i = 0; i < m; i++) check({name, ".rd_addr"}, rdQ[i], 32'(addrs[i]));
            m = (vwIdxQ.size() < n) ? vwIdxQ.size() : n;
            for (int i = 0; i < m; i++) begin
                check({name, ".vwe_idx"}, vwIdxQ[i], 32'(i));
                check({name, ".vwe_data"}, vwDataQ[i], 32'(mem[addrs[i]]));
            end
        end else begin
            check({name, ".wr_count"}, 32'(wrAddrQ.size()), 32'(n));
            check({name, ".rd_count"}, 32'(rdQ.size()), 32'd0);
            check({name, ".vwe_count"}, 32'(vwIdxQ.size()), 32'd0);
            m = (wrAddrQ.size() < n) ? wrAddrQ.size() : n;
            for (int i = 0; i < m; i++) begin
                check({name, ".wr_addr"}, wrAddrQ[i], 32'(addrs[i]));
                check({name, ".wr_data"}, wrDataQ[i], 32'(vreg[i]));
            end
        end
        check({name, ".protocol"}, protoErr, 32'd0);
        check({name, ".hold"}, holdErr, 32'd0);
    endtask

    // Reset asserted while element 2 of a store is stalled on the bus
    task automatic resetMidStore();
        int unsigned d0;
        int k;
        for (int e = 0; e < int'(ELEMS); e++) vreg[e] = DW'($urandom);
        waitMin = 3;
        waitMax = 3;
        @(negedge Clk);
        clearQueues();
        d0 = doneCnt;
        Start = 1'b1; Op = 1'b1; Base = 16'h3000; Stride = 16'h0002; VLen = 5'd8;
        k = 0;
        while (1) begin
            @(negedge Clk);
            k++;
            Start = 1'b0;
            if (wrAddrQ.size() == 2 && WR && !MemRdy) break;
            if (k > 500) begin
                check("rst.reach_elem2_timeout", 32'd0, 32'd1);
                break;
            end
        end
        #2 Reset = 1'b0;
        #1;
        check("rst.addr", 32'(Addr), 32'd0);
        check("rst.rd_wr", 32'({RD, WR}), 32'd0);
        check("rst.dataout", 32'(DataOut), 32'd0);
        check("rst.vidx_vwe", 32'({VIdx, VWE}), 32'd0);
        check("rst.vwrdata", 32'(VWrData), 32'd0);
        check("rst.busy_done_wrap", 32'({Busy, Done, Wrap}), 32'd0);
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        repeat (4) @(negedge Clk);
        check("rst.no_done", doneCnt - d0, 32'd0);
        check("rst.idle_busy", 32'(Busy), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          rop;
        logic [AW-1:0] rbase;
        logic [AW-1:0] rstride;
        logic [IW:0]   rvlen;
        int unsigned   rwait;
        bit            rextra;
        Reset = 1'b0; Start = 1'b0; Op = 1'b0; Base = '0; Stride = '0; VLen = '0;
        repeat (3) @(negedge Clk);
        check("reset.addr", 32'(Addr), 32'd0);
        check("reset.rd_wr_vwe", 32'({RD, WR, VWE}), 32'd0);
        check("reset.data", 32'({DataOut, VWrData}), 32'd0);
        check("reset.vidx", 32'(VIdx), 32'd0);
        check("reset.busy_done_wrap", 32'({Busy, Done, Wrap}), 32'd0);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);

        runTxn(1'b0, 16'h0100, 16'h0001, 5'd16, 0, 0, 1'b0, "ld16");
        runTxn(1'b1, 16'h2000, 16'h0004, 5'd4,  3, 3, 1'b0, "st4_wait3");
        runTxn(1'b0, 16'hFFFE, 16'h0001, 5'd4,  0, 0, 1'b0, "ld_wrap");
        runTxn(1'b0, 16'h1234, 16'h0001, 5'd3,  0, 0, 1'b0, "ld_wrap_clear");
        runTxn(1'b0, 16'h4000, 16'h0001, 5'd0,  0, 0, 1'b0, "ld_vlen0");
        runTxn(1'b1, 16'h4000, 16'h0001, 5'd0,  0, 0, 1'b0, "st_vlen0");
        runTxn(1'b0, 16'h5000, 16'h0003, 5'd20, 0, 0, 1'b0, "ld_clamp");
        runTxn(1'b1, 16'h6000, 16'h0010, 5'd31, 1, 2, 1'b0, "st_clamp");
        runTxn(1'b1, 16'h7777, 16'h0000, 5'd5,  0, 1, 1'b0, "st_stride0");
        runTxn(1'b0, 16'h0040, 16'h0002, 5'd6,  0, 0, 1'b1, "ld_restart");
        runTxn(1'b1, 16'hFFF0, 16'h0008, 5'd4,  0, 0, 1'b1, "st_wrap_restart");

        resetMidStore();
        runTxn(1'b1, 16'h3000, 16'h0002, 5'd8, 0, 2, 1'b0, "st_after_reset");

        for (int t = 0; t < 30; t++) begin
            rop     = 1'($urandom_range(1, 0));
            rbase   = AW'($urandom);
            rstride = ($urandom_range(3, 0) == 0) ? AW'($urandom) : AW'($urandom_range(8, 0));
            rvlen   = (IW+1)'($urandom_range(31, 0));
            rwait   = $urandom_range(2, 0);
            rextra  = (rvlen >= 2) && ($urandom_range(1, 0) == 1);
            runTxn(rop, rbase, rstride, rvlen, 0, rwait, rextra, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
